pool_fmap_buffer: RTL and testbench
===================================

Name: pool_fmap_buffer

Overview:
- Feature-map buffer directly downstream of the convolution/pooling stage (COMPUTATION).
- FILL phase: captures each pooled result and its 2-bit history tag at the address supplied by that stage.
- DRAIN phase: starts after com_end; replays the map in raster order, zero-padded, as an i_load/i_in stream that drives the next layer's COMPUTATION input port.

Parameters:
- OSZ, 6, pooled map edge length (14x14 input, 3x3 conv, 2x2 pool -> 6).
- PAD, 0, zero-padding ring width applied on drain for the next layer (0..3).
- DW, 16, data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pool_valid  in  1  pool_result/addr/history valid this cycle.
- pool_result  in  16  pooled value.
- addr  in  16  linear write address, row-major, 0..OSZ*OSZ-1.
- history  in  2  max-pool winner index for this result.
- com_end  in  1  producer finished current map (level or pulse; rising level sampled).
- next_ready  in  1  downstream may accept a word this cycle.
- i_load  out  1  i_in valid this cycle.
- i_in  out  16  streamed feature value (0 at pad positions).
- hist_out  out  2  history tag aligned with i_in (0 at pad positions).
- drain_done  out  1  one-cycle pulse after the last word.
- wr_cnt  out  16  results accepted in current fill.
- err  out  1  sticky: out-of-range addr, or pool_valid outside FILL.

Behaviour:
- Reset (async, any state): state=FILL; i_load, i_in, hist_out, drain_done, wr_cnt, err all 0; row/col counters 0. Memory contents are not cleared.
- States: FILL, DRAIN, DONE.
- FILL:
  - pool_valid with addr < OSZ*OSZ: write mem[addr]={history,pool_result} on that edge; wr_cnt+1.
  - A rewrite of the same addr overwrites and still counts.
  - addr >= OSZ*OSZ: no write, err<=1.
  - FILL -> DRAIN on the edge where com_end=1.
  - pool_valid and com_end in the same cycle: the write is performed first, then the transition.
- DRAIN:
  - Counters r,c sweep 0..E-1 row-major, E=OSZ+2*PAD.
  - Position is pad if r<PAD, r>=OSZ+PAD, c<PAD, or c>=OSZ+PAD; otherwise it reads mem[(r-PAD)*OSZ+(c-PAD)].
  - Registered output, combinational array read: a cycle with next_ready=1 gives i_load=1 and the position's word on the next edge, then counters advance.
  - next_ready=0: i_load<=0, counters hold, i_in holds its last value. No word is dropped or duplicated.
  - First word appears one cycle after DRAIN entry if next_ready=1.
  - Total E*E words with i_load=1.
  - pool_valid in DRAIN: ignored, err<=1.
- DONE (one cycle): i_load=0, drain_done=1, wr_cnt<=0, counters<=0; -> FILL next edge.
- com_end held high across DONE->FILL does not retrigger. A new rising com_end is required (edge-detect register).
- Widths: row/col counters 8 bits; address product computed in 16 bits; OSZ*OSZ <= 1024.

Decomposition:
- Package cnn_pkg:
  - DW=16, HIST_W=2.
  - state enum {FILL, DRAIN, DONE}.
  - localparam function for E and map size.
- One sub-module: fmap_ram.
  - Depth OSZ*OSZ, width DW+2.
  - One write port, one asynchronous read port, no reset.

Test Plan:
- Write addr 0..35 with values 1..36, history=i%4, then com_end, next_ready=1, PAD=0 -> 36 consecutive i_load cycles with i_in=1..36 and hist_out=0,1,2,3,...; drain_done one cycle after the 36th word; wr_cnt 36 then 0.
- PAD=1, same fill -> 64 words: first 9 are 0, the 10th is 1, row 1 ends 6 then 0; last 9 are 0.
- Same data, next_ready toggled 1,0,1,0 during drain -> i_load mirrors next_ready one cycle later; sequence still exactly 1..36.
- Write addr 36 value 99 in FILL -> err=1, wr_cnt unchanged; drain still yields 1..36 only.
- pool_valid at addr 35 value 77 in the same cycle as com_end -> last drained word is 77.
- Assert reset at the 10th drain word -> all outputs 0 asynchronously, state FILL; a new fill/drain of 1..36 completes correctly.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and constants for the CNN feature-map datapath.
//   DW       : default feature word width
//   HIST_W   : max-pool history tag width
//   state_t  : feature-map buffer phase (FILL, DRAIN, DONE)
//   edge_len : padded edge length of a drained map
//   map_size : number of words in an unpadded map
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int DW     = 16;
  localparam int HIST_W = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int edge_len(input int osz, input int pad);
    return osz + 2 * pad;
  endfunction

  function automatic int map_size(input int osz);
    return osz * osz;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// -----------------------------------------------------------------------------
// fmap_ram
// Feature-map storage: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable (caller guarantees waddr < DEPTH)
//   waddr : write address
//   wdata : write word {history, value}
//   raddr : read address (caller guarantees raddr < DEPTH)
//   rdata : combinational read word
// -----------------------------------------------------------------------------
module fmap_ram #(
  parameter int DEPTH = 36,
  parameter int WIDTH = 18,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; a fresh fill overwrites it, and a reset
  // branch would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_fmap_buffer.sv
// -----------------------------------------------------------------------------
// pool_fmap_buffer
// Captures pooled results (with history tags) at producer-supplied addresses,
// then after com_end replays the map in raster order with a zero pad ring as an
// i_load/i_in stream for the next layer.
//   clk, reset    : clock, asynchronous active-high reset
//   pool_valid    : pool_result/addr/history valid
//   pool_result   : pooled value
//   addr          : row-major write address
//   history       : max-pool winner index
//   com_end       : producer finished the map (rising level starts drain)
//   next_ready    : downstream accepts a word this cycle
//   i_load        : i_in/hist_out valid
//   i_in          : streamed value (0 at pad positions)
//   hist_out      : history tag aligned with i_in (0 at pad positions)
//   drain_done    : one-cycle pulse after the last word
//   wr_cnt        : results accepted in the current fill
//   err           : sticky error (bad addr, or pool_valid outside FILL)
// -----------------------------------------------------------------------------
module pool_fmap_buffer
  import cnn_pkg::*;
#(
  parameter int OSZ = 6,
  parameter int PAD = 0,
  parameter int DW  = cnn_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pool_valid,
  input  logic [DW-1:0]     pool_result,
  input  logic [15:0]       addr,
  input  logic [HIST_W-1:0] history,
  input  logic              com_end,
  input  logic              next_ready,
  output logic              i_load,
  output logic [DW-1:0]     i_in,
  output logic [HIST_W-1:0] hist_out,
  output logic              drain_done,
  output logic [15:0]       wr_cnt,
  output logic              err
);

  localparam int MAP = map_size(OSZ);
  localparam int E   = edge_len(OSZ, PAD);
  localparam int AW  = (MAP > 1) ? $clog2(MAP) : 1;
  localparam int WW  = DW + HIST_W;

  localparam logic [15:0] MAP16 = 16'(MAP);
  localparam logic [15:0] OSZ16 = 16'(OSZ);
  localparam logic [15:0] PAD16 = 16'(PAD);
  localparam logic [7:0]  LAST8 = 8'(E - 1);

  state_t         state_q, state_d;
  logic           com_end_q;
  logic [7:0]     row_q, col_q;
  logic           com_rise, addr_ok, we, in_map, last_pos;
  logic [15:0]    rr, cc, rd_lin;
  logic [AW-1:0]  raddr;
  logic [WW-1:0]  rd_word;

  // Only a fresh rising com_end starts a drain, so a level held through
  // DONE -> FILL cannot retrigger.
  assign com_rise = com_end & ~com_end_q;
  assign addr_ok  = (addr < MAP16);
  assign we       = (state_q == FILL) && pool_valid && addr_ok;

  // Offsetting by PAD in 16 bits lets unsigned wrap flag the leading pad
  // rows/cols: anything left of or above the map lands >= OSZ.
  assign rr       = {8'd0, row_q} - PAD16;
  assign cc       = {8'd0, col_q} - PAD16;
  assign rd_lin   = rr * OSZ16 + cc;
  assign in_map   = (rr < OSZ16) && (cc < OSZ16) && (rd_lin < MAP16);
  assign raddr    = in_map ? rd_lin[AW-1:0] : '0;
  assign last_pos = (row_q == LAST8) && (col_q == LAST8);

  fmap_ram #(
    .DEPTH (MAP),
    .WIDTH (WW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (addr[AW-1:0]),
    .wdata ({history, pool_result}),
    .raddr (raddr),
    .rdata (rd_word)
  );

  // NOTE: every signal gets a default before the case so no path leaves
  // state_d unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (com_rise) state_d = DRAIN;
      DRAIN:   if (next_ready && last_pos) state_d = DONE;
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      com_end_q  <= 1'b0;
      i_load     <= 1'b0;
      i_in       <= '0;
      hist_out   <= '0;
      drain_done <= 1'b0;
      wr_cnt     <= '0;
      err        <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      com_end_q  <= com_end;
      drain_done <= 1'b0;
      unique case (state_q)
        FILL: begin
          i_load <= 1'b0;
          if (pool_valid) begin
            if (addr_ok) wr_cnt <= wr_cnt + 16'd1;
            else         err    <= 1'b1;
          end
        end
        DRAIN: begin
          if (pool_valid) err <= 1'b1;
          if (next_ready) begin
            i_load   <= 1'b1;
            i_in     <= in_map ? rd_word[DW-1:0]     : '0;
            hist_out <= in_map ? rd_word[WW-1:DW]    : '0;
            if (col_q == LAST8) begin
              col_q <= '0;
              row_q <= row_q + 8'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end else begin
            i_load <= 1'b0;
          end
        end
        DONE: begin
          i_load     <= 1'b0;
          drain_done <= 1'b1;
          wr_cnt     <= '0;
          row_q      <= '0;
          col_q      <= '0;
        end
        default: i_load <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_fmap_buffer.sv
module tb_pool_fmap_buffer;

  localparam int OSZ = 6;
  localparam int MAP = OSZ * OSZ;

  logic clk = 1'b0;
  logic reset;
  logic pool_valid;
  logic [15:0] pool_result;
  logic [15:0] addr;
  logic [1:0]  history;
  logic com_end;
  logic next_ready;

  logic [1:0]       i_load_v, drain_done_v, err_v;
  logic [1:0][15:0] i_in_v, wr_cnt_v;
  logic [1:0][1:0]  hist_v;

  always #5 clk = ~clk;

  pool_fmap_buffer #(.OSZ(OSZ), .PAD(0), .DW(16)) dut0 (
    .clk(clk), .reset(reset), .pool_valid(pool_valid), .pool_result(pool_result),
    .addr(addr), .history(history), .com_end(com_end), .next_ready(next_ready),
    .i_load(i_load_v[0]), .i_in(i_in_v[0]), .hist_out(hist_v[0]),
    .drain_done(drain_done_v[0]), .wr_cnt(wr_cnt_v[0]), .err(err_v[0])
  );

  pool_fmap_buffer #(.OSZ(OSZ), .PAD(1), .DW(16)) dut1 (
    .clk(clk), .reset(reset), .pool_valid(pool_valid), .pool_result(pool_result),
    .addr(addr), .history(history), .com_end(com_end), .next_ready(next_ready),
    .i_load(i_load_v[1]), .i_in(i_in_v[1]), .hist_out(hist_v[1]),
    .drain_done(drain_done_v[1]), .wr_cnt(wr_cnt_v[1]), .err(err_v[1])
  );

  int checks = 0;
  int errors = 0;
  int exp_wr = 0;
  logic [17:0] mdl [MAP];
  logic [17:0] got [2][$];
  int pad_of [2] = '{0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: padded raster position idx of the map held in mdl.
  function automatic logic [17:0] exp_word(input int pad, input int idx);
    int e, r, c;
    e = OSZ + 2 * pad;
    r = idx / e;
    c = idx % e;
    if (r < pad || r >= OSZ + pad || c < pad || c >= OSZ + pad) return 18'd0;
    return mdl[(r - pad) * OSZ + (c - pad)];
  endfunction

  task automatic write(input int a, input logic [15:0] v, input logic [1:0] h);
    pool_valid = 1'b1; addr = 16'(a); pool_result = v; history = h;
    @(posedge clk); #1;
    pool_valid = 1'b0;
    if (a < MAP) begin
      mdl[a] = {h, v};
      exp_wr++;
    end
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) write(i, 16'(i + 1), 2'(i % 4));
  endtask

  task automatic start_drain(input bit with_wr, input int a, input logic [15:0] v,
                             input logic [1:0] h, input bit hold);
    com_end = 1'b1;
    if (with_wr) begin
      pool_valid = 1'b1; addr = 16'(a); pool_result = v; history = h;
      mdl[a] = {h, v};
      exp_wr++;
    end
    @(posedge clk); #1;
    pool_valid = 1'b0;
    if (!hold) com_end = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle 1,0,1,0..., 2: random.
  task automatic drain(input int mode, input int stop_at, input int inj_at);
    int  n [2];
    bit  done [2];
    int  lim [2];
    logic r;
    for (int d = 0; d < 2; d++) begin
      n[d] = 0;
      done[d] = 1'b0;
      lim[d] = (OSZ + 2 * pad_of[d]) * (OSZ + 2 * pad_of[d]);
      got[d].delete();
      check($sformatf("wr_cnt_at_drain d%0d", d), wr_cnt_v[d], exp_wr);
    end
    for (int cyc = 0; cyc < 1000 && !(done[0] && done[1]); cyc++) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = ((cyc % 2) == 0);
      else                r = 1'($urandom_range(0, 1));
      next_ready = r;
      if (inj_at > 0 && cyc == inj_at) begin
        pool_valid = 1'b1; addr = 16'd0; pool_result = 16'hdead; history = 2'd3;
      end else begin
        pool_valid = 1'b0;
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (!done[d]) begin
          if (n[d] < lim[d]) begin
            check($sformatf("iload_mirror d%0d c%0d", d, cyc), i_load_v[d], r);
            check($sformatf("early_done d%0d c%0d", d, cyc), drain_done_v[d], 1'b0);
            if (i_load_v[d]) begin
              got[d].push_back({hist_v[d], i_in_v[d]});
              n[d]++;
            end
          end else begin
            check($sformatf("drain_done d%0d", d), drain_done_v[d], 1'b1);
            check($sformatf("iload_at_done d%0d", d), i_load_v[d], 1'b0);
            check($sformatf("wr_cnt_cleared d%0d", d), wr_cnt_v[d], 16'd0);
            done[d] = 1'b1;
          end
        end
      end
      if (stop_at > 0 && n[0] == stop_at) break;
    end
    pool_valid = 1'b0;
    next_ready = 1'b0;
    if (stop_at == 0) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("drain_timeout d%0d", d), done[d], 1'b1);
        check($sformatf("word_count d%0d", d), got[d].size(), lim[d]);
        for (int i = 0; i < lim[d] && i < got[d].size(); i++)
          check($sformatf("word d%0d i%0d", d, i), got[d][i], exp_word(pad_of[d], i));
      end
      exp_wr = 0;
    end
  endtask

  initial begin
    reset = 1'b1; pool_valid = 1'b0; pool_result = '0; addr = '0; history = '0;
    com_end = 1'b0; next_ready = 1'b0;
    for (int i = 0; i < MAP; i++) mdl[i] = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_iload d%0d", d), i_load_v[d], 1'b0);
      check($sformatf("rst_iin d%0d", d), i_in_v[d], 16'd0);
      check($sformatf("rst_done d%0d", d), drain_done_v[d], 1'b0);
      check($sformatf("rst_wrcnt d%0d", d), wr_cnt_v[d], 16'd0);
      check($sformatf("rst_err d%0d", d), err_v[d], 1'b0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Ramp fill, continuous drain, literal expectations.
    fill_ramp(MAP);
    check("wr_cnt_after_fill", wr_cnt_v[0], 16'd36);
    start_drain(1'b0, 0, '0, '0, 1'b0);
    drain(0, 0, 0);
    for (int i = 0; i < MAP; i++)
      check($sformatf("ramp_pad0 i%0d", i), got[0][i], {2'(i % 4), 16'(i + 1)});
    check("pad1_first9", got[1][8], 18'd0);
    check("pad1_tenth", got[1][9], {2'd0, 16'd1});
    check("pad1_row1_end", got[1][14], {2'd1, 16'd6});
    check("pad1_row1_pad", got[1][15], 18'd0);
    check("pad1_last", got[1][63], 18'd0);
    check("err_clean", err_v[0], 1'b0);

    // Toggled ready, com_end held high through DONE -> FILL.
    fill_ramp(MAP);
    start_drain(1'b0, 0, '0, '0, 1'b1);
    drain(1, 0, 0);
    next_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("no_retrigger k%0d", k), i_load_v, 2'b00);
    end
    com_end = 1'b0; next_ready = 1'b0;

    // Out-of-range write.
    fill_ramp(MAP);
    write(MAP, 16'd99, 2'd0);
    check("err_bad_addr", err_v[0], 1'b1);
    check("wr_cnt_bad_addr", wr_cnt_v[0], 16'd36);
    start_drain(1'b0, 0, '0, '0, 1'b0);
    drain(2, 0, 0);

    // Write coincident with com_end.
    fill_ramp(MAP - 1);
    start_drain(1'b1, MAP - 1, 16'd77, 2'd1, 1'b0);
    drain(0, 0, 0);
    check("last_word_77", got[0][MAP-1][15:0], 16'd77);

    // Random fill with rewrites, random ready.
    for (int i = 0; i < MAP; i++)
      write(i, 16'($urandom), 2'($urandom_range(0, 3)));
    for (int k = 0; k < 10; k++)
      write($urandom_range(0, MAP - 1), 16'($urandom), 2'($urandom_range(0, 3)));
    start_drain(1'b0, 0, '0, '0, 1'b0);
    drain(2, 0, 0);

    // Asynchronous reset mid-drain.
    fill_ramp(MAP);
    start_drain(1'b0, 0, '0, '0, 1'b0);
    drain(0, 10, 0);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_iload d%0d", d), i_load_v[d], 1'b0);
      check($sformatf("arst_iin d%0d", d), i_in_v[d], 16'd0);
      check($sformatf("arst_hist d%0d", d), hist_v[d], 2'd0);
      check($sformatf("arst_wrcnt d%0d", d), wr_cnt_v[d], 16'd0);
      check($sformatf("arst_err d%0d", d), err_v[d], 1'b0);
    end
    exp_wr = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    fill_ramp(MAP);
    start_drain(1'b0, 0, '0, '0, 1'b0);
    drain(0, 0, 3);
    for (int d = 0; d < 2; d++)
      check($sformatf("err_pv_in_drain d%0d", d), err_v[d], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
